// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter and its register scoreboard.
// Holds default widths, grant-pointer encodings and the register-zero index.
package wb_arbiter_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same register in one cycle leaves it set; x0 is never busy.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              set_en,
  input  logic [AWIDTH-1:0] set_rd,
  input  logic              clr_en,
  input  logic [AWIDTH-1:0] clr_rd,
  input  logic [AWIDTH-1:0] rs1,
  input  logic [AWIDTH-1:0] rs2,
  output logic              busy_rs1,
  output logic              busy_rs2
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DEPTH-1:0] bits_r;
  logic [DEPTH-1:0] bits_next_s;

  // Next-state: clear first so a same-cycle set on the same register wins.
  always_comb begin
    bits_next_s = bits_r;
    if (clr_en) begin
      bits_next_s[clr_rd] = 1'b0;
    end else begin
      bits_next_s = bits_next_s;
    end
    if (set_en) begin
      bits_next_s[set_rd] = 1'b1;
    end else begin
      bits_next_s = bits_next_s;
    end
    bits_next_s[REG_ZERO] = 1'b0;
  end

  // Scoreboard state register with synchronous active-low clear.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      bits_r <= '0;
    end else begin
      bits_r <= bits_next_s;
    end
  end

  // Query ports read registered state only; x0 reads as idle.
  always_comb begin
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    if (rs1 != AWIDTH'(REG_ZERO)) begin
      busy_rs1 = bits_r[rs1];
    end else begin
      busy_rs1 = 1'b0;
    end
    if (rs2 != AWIDTH'(REG_ZERO)) begin
      busy_rs2 = bits_r[rs2];
    end else begin
      busy_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter between ALU and load unit, driving the
// register-file write port from registers and tracking pending destinations.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_alu_valid,
  input  logic [AWIDTH-1:0] w_alu_rd,
  input  logic [DWIDTH-1:0] w_alu_data,
  output logic              w_alu_ready,
  input  logic              w_mem_valid,
  input  logic [AWIDTH-1:0] w_mem_rd,
  input  logic [DWIDTH-1:0] w_mem_data,
  output logic              w_mem_ready,
  input  logic              w_issue_valid,
  input  logic [AWIDTH-1:0] w_issue_rd,
  input  logic [AWIDTH-1:0] w_rs1,
  input  logic [AWIDTH-1:0] w_rs2,
  output logic              w_busy_rs1,
  output logic              w_busy_rs2,
  output logic              w_we,
  output logic [AWIDTH-1:0] w_addr_rd,
  output logic [DWIDTH-1:0] w_data_rd
);

  gnt_e              ptr_r;
  gnt_e              ptr_next_s;
  logic              alu_ready_s;
  logic              mem_ready_s;
  logic              accept_s;
  logic              acc_nz_s;
  logic [AWIDTH-1:0] acc_rd_s;
  logic [DWIDTH-1:0] acc_data_s;
  logic              we_r;
  logic [AWIDTH-1:0] addr_r;
  logic [DWIDTH-1:0] data_r;

  // Grant selection: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    alu_ready_s = 1'b0;
    mem_ready_s = 1'b0;
    ptr_next_s  = ptr_r;
    if (w_alu_valid && (!w_mem_valid || (ptr_r == GNT_ALU))) begin
      alu_ready_s = 1'b1;
      ptr_next_s  = GNT_MEM;
    end else if (w_mem_valid) begin
      mem_ready_s = 1'b1;
      ptr_next_s  = GNT_ALU;
    end else begin
      ptr_next_s  = ptr_r;
    end
  end

  // Accepted write-back payload mux.
  always_comb begin
    acc_rd_s   = w_alu_rd;
    acc_data_s = w_alu_data;
    if (mem_ready_s) begin
      acc_rd_s   = w_mem_rd;
      acc_data_s = w_mem_data;
    end else begin
      acc_rd_s   = w_alu_rd;
      acc_data_s = w_alu_data;
    end
  end

  assign accept_s    = alu_ready_s | mem_ready_s;
  assign acc_nz_s    = accept_s && (acc_rd_s != AWIDTH'(REG_ZERO));
  assign w_alu_ready = alu_ready_s;
  assign w_mem_ready = mem_ready_s;

  // Pointer and write-port registers; x0 writes load address/data but never enable.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      ptr_r  <= GNT_ALU;
      we_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      ptr_r <= ptr_next_s;
      we_r  <= acc_nz_s;
      if (accept_s) begin
        addr_r <= acc_rd_s;
        data_r <= acc_data_s;
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  assign w_we      = we_r;
  assign w_addr_rd = addr_r;
  assign w_data_rd = data_r;

  wb_scoreboard #(
    .AWIDTH(AWIDTH)
  ) u_scoreboard (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .set_en  (w_issue_valid),
    .set_rd  (w_issue_rd),
    .clr_en  (acc_nz_s),
    .clr_rd  (acc_rd_s),
    .rs1     (w_rs1),
    .rs2     (w_rs2),
    .busy_rs1(w_busy_rs1),
    .busy_rs2(w_busy_rs2)
  );

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 2-read/1-write register file.
- Two producers share the single register-file write port: the ALU and the load unit. The block arbitrates between them round-robin and drives the write port from registered outputs.
- It also tracks pending destination registers, so decode can stall on read-after-write hazards.
- Position: between the execute/memory stages and the register file; decode queries the busy outputs.

Parameters:
- DWIDTH, 32, data width of the register file.
- AWIDTH, 5, register address width; DEPTH = 1<<AWIDTH.

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  reset; synchronous, active-low.
- w_alu_valid  in  1  ALU write-back request.
- w_alu_rd  in  AWIDTH  ALU destination register.
- w_alu_data  in  DWIDTH  ALU result.
- w_alu_ready  out  1  ALU request accepted this cycle.
- w_mem_valid  in  1  load write-back request.
- w_mem_rd  in  AWIDTH  load destination register.
- w_mem_data  in  DWIDTH  load data.
- w_mem_ready  out  1  load request accepted this cycle.
- w_issue_valid  in  1  decode issued an instruction that writes w_issue_rd.
- w_issue_rd  in  AWIDTH  destination of the issued instruction.
- w_rs1  in  AWIDTH  decode source 1 query.
- w_rs2  in  AWIDTH  decode source 2 query.
- w_busy_rs1  out  1  w_rs1 has a pending write.
- w_busy_rs2  out  1  w_rs2 has a pending write.
- w_we  out  1  register-file write enable (registered).
- w_addr_rd  out  AWIDTH  register-file write address (registered).
- w_data_rd  out  DWIDTH  register-file write data (registered).

Behaviour:
- Reset (w_rst low at a rising edge):
  - w_we=0, w_addr_rd=0, w_data_rd=0.
  - All scoreboard bits cleared.
  - Priority pointer set to ALU.
  - Reset overrides any same-cycle request or issue; in-flight requests are dropped, and producers must re-present them after reset.
- Ready signals: combinational from valids and pointer; at most one is high per cycle.
  - Only one valid: that requester gets ready.
  - Both valid: the requester named by the pointer gets ready; the other sees ready=0 and must hold valid/rd/data stable.
- Pointer update: after any accept, the pointer moves to the non-granted requester. No accept: pointer holds. Result: strict alternation under continuous contention; no starvation.
- Accept = valid & ready, sampled at the rising edge. At the next edge:
  - w_we = 1 if the accepted rd != 0, else 0.
  - w_addr_rd / w_data_rd load the accepted rd/data.
  - Latency: exactly 1 cycle from accept to w_we.
- No accept that cycle: w_we=0; w_addr_rd/w_data_rd hold their previous values.
- Writes to x0: still accepted (ready high), but w_we stays 0 and the scoreboard is not touched.
- Scoreboard, DEPTH bits, updated at the edge:
  - Set: bit[w_issue_rd] when w_issue_valid and w_issue_rd != 0.
  - Clear: bit[rd] of the accepted write-back.
  - Same rd set and cleared in one cycle: set wins, because the new producer supersedes the old.
  - Bit 0 is always 0.
- Busy outputs: combinational read of the registered scoreboard; no same-cycle bypass. A query of x0 returns 0.
- Producers never present a write-back without a prior issue. An accept for a non-busy rd is legal and leaves that bit at 0.
- Throughput: one write per cycle maximum; w_we may stay high on back-to-back cycles.

Decomposition:
- Shared package holds:
  - DWIDTH/AWIDTH defaults.
  - Grant encodings GNT_ALU=1'b0, GNT_MEM=1'b1 (pointer values).
  - Register-zero constant.
- One sub-module, wb_scoreboard: DEPTH-bit set/clear array, two combinational query ports, x0 forced to 0, set-wins priority, synchronous active-low clear.
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset then idle: hold w_rst=0 for 2 edges, release.
  -> w_we=0, w_addr_rd=0, w_data_rd=0, busy outputs 0 for all queries.
- Single ALU write: issue rd=5, next cycle ALU valid rd=5 data=0xDEADBEEF.
  -> w_alu_ready=1 that cycle; next edge w_we=1, w_addr_rd=5, w_data_rd=0xDEADBEEF.
  -> w_busy for rs=5 is 1 after the issue edge and 0 after the accept edge.
- Contention: both valid continuously for 4 cycles, ALU rd=1, mem rd=2, each re-presented after its accept.
  -> grant order ALU, MEM, ALU, MEM; w_addr_rd sequence 1,2,1,2 with w_we high every cycle.
- x0 write: mem valid rd=0 data=0x1234.
  -> w_mem_ready=1; next cycle w_we=0; scoreboard unchanged.
- Collision: rd=7 busy; in one cycle issue rd=7 and accept ALU write-back rd=7 data=0x55.
  -> w_we=1 addr=7 data=0x55 next cycle; busy for rs=7 stays 1.
- Reset mid-operation: both valid and rd=3 busy, assert w_rst=0 for one edge.
  -> next cycle w_we=0, busy for rs=3 is 0; after release with both valid, ALU is granted first.
